ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Round-robin AHB arbiter sharing the single AHB-to-APB bridge slave port among
//  NUM_MASTERS AHB requesters. Drives per-master grants plus address- and data-phase
//  owner indices for the upstream HADDR/HWDATA muxes. Bounds each tenure with a beat
//  quota and honours HLOCK; parks on master 0 when idle.
// PARAMETERS
//  NUM_MASTERS  4   number of requesting masters (1..8)
//  MAX_BEATS    8   accepted beats per tenure before forced re-arbitration (>=1)
//  MW           2   owner index width, $clog2(NUM_MASTERS), min 1
// PORTS
//  clk          in   1            single clock; all state on rising edge
//  hreset       in   1            reset, asynchronous, active-high
//  hbusreq      in   NUM_MASTERS  per-master bus request
//  hlock        in   NUM_MASTERS  per-master locked-sequence request
//  htrans       in   2            HTRANS of current address-phase owner (muxed upstream)
//  hready       in   1            transfer-complete from bridge slave
//  hgrant       out  NUM_MASTERS  one-hot grant (registered)
//  hmaster      out  MW           address-phase owner index (registered)
//  hmaster_data out  MW           data-phase owner index, selects HWDATA mux
//  hmastlock    out  1            current address phase is locked
// BEHAVIOUR
//  Reset: hgrant=1 (master 0 parked), hmaster=0, hmaster_data=0, hmastlock=0,
//   beat_cnt=0, last_grant=0, state=PARK. Reset mid-transfer aborts to PARK at once.
//  States: PARK (no request; master 0 owns, htrans expected IDLE), OWN (requester
//   owns, beats counted), LOCK (owner hlock high; re-arbitration forbidden).
//  All updates occur only on edges with hready=1; hready=0 freezes every register.
//  beat: hready=1 and htrans[1]=1 (NONSEQ/SEQ). beat_cnt increments per beat,
//   saturates at MAX_BEATS-1, clears to 0 on any owner change.
//  Re-arbitrate (hready=1 and state!=LOCK) when any of:
//   a) owner's hbusreq=0; b) state=PARK and any hbusreq=1;
//   c) beat accepted with beat_cnt==MAX_BEATS-1 and another master requesting.
//  Winner: first requesting master scanning last_grant+1, +2, ... mod NUM_MASTERS;
//   current owner scanned last. No requesters -> master 0, state PARK.
//  Latency: hbusreq sampled at edge n (hready=1) -> hgrant/hmaster valid after edge n.
//   hmaster_data <= hmaster on each hready=1 edge (one-transfer lag).
//  New owner differs -> last_grant<=winner, beat_cnt<=0; same owner kept -> no change.
//  LOCK entry: owner hlock=1 on hready edge; hmastlock<=1. Exit when owner hlock=0
//   on hready edge; the locked final beat completes before any grant change.
//  hmastlock=0 in PARK and OWN. Owner's hbusreq dropping while in LOCK is ignored
//   until hlock falls.
//  Only one hgrant bit high at any time; hgrant==(1<<hmaster) always.
//  NUM_MASTERS=1: hgrant=1 permanently; quota re-arbitration never changes owner.
// TESTING
//  1 reset, no requests, 5 cycles -> hgrant=0001, hmaster=0, hmastlock=0, state PARK.
//  2 hbusreq=0110 same cycle, hready=1 -> grant 1 next cycle; after owner drops,
//    grant 2; hmaster_data trails hmaster by one hready cycle.
//  3 master 2 holds hbusreq, master 3 requests, 8 NONSEQ/SEQ beats -> grant moves to
//    3 right after 8th beat accepted; beat_cnt back to 0.
//  4 master 1 hlock=1 for 12 beats, master 0 requesting -> hgrant stays 0010,
//    hmastlock=1 throughout; grant moves to 0 on edge after hlock falls.
//  5 hready=0 for 4 cycles during handover request -> hgrant, hmaster frozen; switch
//    occurs on first hready=1 edge.
//  6 hreset pulse mid-burst while master 3 owns -> same-cycle hgrant=0001,
//    hmaster=hmaster_data=0, hmastlock=0.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Round-robin arbiter sharing one AHB slave port among NUM_MASTERS requesters.
// Grants are bounded by a beat quota, honour HLOCK, and park on master 0 when idle.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_BEATS   = 8,
  parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  localparam int              CW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(MAX_BEATS - 1);
  localparam logic [MW:0]     N_EXT    = (MW + 1)'(NUM_MASTERS);
  localparam logic [MW-1:0]   LAST_IDX = MW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {st_park, st_own, st_lock} state_t;

  state_t                 state_reg, state_next;
  logic [MW-1:0]          hmaster_reg, hmaster_next;
  logic [MW-1:0]          hmaster_data_reg;
  logic [MW-1:0]          last_grant_reg, last_grant_next;
  logic [CW-1:0]          beat_cnt_reg, beat_cnt_next;
  logic [NUM_MASTERS-1:0] hgrant_reg, hgrant_next;
  logic                   hmastlock_reg, hmastlock_next;

  logic                   htrans_unused;
  logic                   beat, owner_req, owner_lock, any_req, other_req;
  logic                   quota_hit, rearb;
  logic [MW-1:0]          scan_base, offset, winner;
  logic [NUM_MASTERS-1:0] req_rot, req_first;
  logic [MW:0]            win_sum;

  // Only the upper HTRANS bit distinguishes an active beat from IDLE/BUSY.
  assign htrans_unused = htrans[0];
  assign beat          = htrans[1];

  assign owner_req  = |(hbusreq & hgrant_reg);
  assign owner_lock = |(hlock & hgrant_reg);
  assign other_req  = |(hbusreq & ~hgrant_reg);
  assign any_req    = |hbusreq;
  assign quota_hit  = beat && (beat_cnt_reg == CNT_MAX);
  assign rearb      = !owner_req || ((state_reg == st_park) && any_req)
                    || (quota_hit && other_req);

  // Rotate requests so bit 0 is the master right after last_grant; the current
  // owner lands in the top bit and is therefore considered last.
  assign scan_base = (last_grant_reg == LAST_IDX) ? '0 : last_grant_reg + MW'(1);
  assign req_rot   = NUM_MASTERS'({hbusreq, hbusreq} >> scan_base);
  assign req_first = req_rot & (~req_rot + NUM_MASTERS'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_enc
      logic [MW-1:0] acc;
      if (gi == 0) begin : g_first
        assign acc = '0;
      end else begin : g_rest
        assign acc = g_enc[gi-1].acc | (req_first[gi] ? MW'(gi) : '0);
      end
      assign hgrant_next[gi] = (hmaster_next == MW'(gi));
    end
  endgenerate

  assign offset  = g_enc[NUM_MASTERS-1].acc;
  assign win_sum = {1'b0, scan_base} + {1'b0, offset};
  assign winner  = (win_sum >= N_EXT) ? MW'(win_sum - N_EXT) : win_sum[MW-1:0];

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) begin
      state_reg        <= st_park;
      hmaster_reg      <= '0;
      hmaster_data_reg <= '0;
      last_grant_reg   <= '0;
      beat_cnt_reg     <= '0;
      hgrant_reg       <= NUM_MASTERS'(1);
      hmastlock_reg    <= 1'b0;
    end else if (hready) begin
      state_reg        <= state_next;
      hmaster_reg      <= hmaster_next;
      hmaster_data_reg <= hmaster_reg;
      last_grant_reg   <= last_grant_next;
      beat_cnt_reg     <= beat_cnt_next;
      hgrant_reg       <= hgrant_next;
      hmastlock_reg    <= hmastlock_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hmaster_next    = hmaster_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    if (hready) begin
      // A locked owner keeps the bus until it drops hlock; that last locked
      // edge only leaves LOCK, so the grant can move on the following edge.
      if (state_reg == st_lock) begin
        if (!owner_lock) state_next = st_own;
      end else if ((state_reg == st_own) && owner_lock) begin
        state_next = st_lock;
      end else if (rearb) begin
        if (any_req) begin
          hmaster_next = winner;
          state_next   = st_own;
        end else begin
          hmaster_next = '0;
          state_next   = st_park;
        end
      end
      if (hmaster_next != hmaster_reg) begin
        last_grant_next = hmaster_next;
        beat_cnt_next   = '0;
      end else if (beat && (beat_cnt_reg != CNT_MAX)) begin
        beat_cnt_next = beat_cnt_reg + CW'(1);
      end
    end
  end

  always_comb begin
    hmastlock_next = (state_next == st_lock);
  end

  assign hgrant       = hgrant_reg;
  assign hmaster      = hmaster_reg;
  assign hmaster_data = hmaster_data_reg;
  assign hmastlock    = hmastlock_reg;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scenarios plus random traffic for ahb_bus_arbiter, checked against a
// round-robin reference model built from the arbitration rules.
module tb_ahb_bus_arbiter;
  localparam int N  = 4;
  localparam int MB = 8;
  localparam int MW = 2;
  localparam int PARK = 0, OWN = 1, LOCK = 2;

  logic          clk = 1'b0;
  logic          hreset;
  logic [N-1:0]  hbusreq, hlock, hgrant;
  logic [1:0]    htrans;
  logic          hready;
  logic [MW-1:0] hmaster, hmaster_data;
  logic          hmastlock;

  int n_checks = 0;
  int n_fail   = 0;
  int m_owner, m_data, m_last, m_cnt, m_mode;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_BEATS(MB), .MW(MW)) dut (
    .clk(clk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
    .hmaster_data(hmaster_data), .hmastlock(hmastlock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_data = 0; m_last = 0; m_cnt = 0; m_mode = PARK;
  endtask

  task automatic model_step();
    int req, lk, nxt, c;
    bit beat, own_req, own_lock, any_req, other_req, rearb;
    if (hready) begin
      req       = int'(hbusreq);
      lk        = int'(hlock);
      beat      = htrans[1];
      own_req   = ((req >> m_owner) & 1) != 0;
      own_lock  = ((lk >> m_owner) & 1) != 0;
      any_req   = req != 0;
      other_req = (req & ~(1 << m_owner)) != 0;
      m_data    = m_owner;
      nxt       = m_owner;
      if (m_mode == LOCK) begin
        if (!own_lock) m_mode = OWN;
      end else if (m_mode == OWN && own_lock) begin
        m_mode = LOCK;
      end else begin
        rearb = !own_req || (m_mode == PARK && any_req) || (beat && m_cnt == MB - 1 && other_req);
        if (rearb) begin
          if (any_req) begin
            m_mode = OWN;
            for (int k = 1; k <= N; k++) begin
              c = (m_last + k) % N;
              if (((req >> c) & 1) != 0) begin
                nxt = c;
                break;
              end
            end
          end else begin
            m_mode = PARK;
            nxt    = 0;
          end
        end
      end
      if (nxt != m_owner) begin
        m_owner = nxt; m_last = nxt; m_cnt = 0;
      end else if (beat && m_cnt < MB - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_all();
    check("hgrant", 32'(hgrant), 32'(1 << m_owner));
    check("hmaster", 32'(hmaster), 32'(m_owner));
    check("hmaster_data", 32'(hmaster_data), 32'(m_data));
    check("hmastlock", 32'(hmastlock), (m_mode == LOCK) ? 32'd1 : 32'd0);
  endtask

  // One clock: DUT and model both consume the inputs at the rising edge,
  // outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (hreset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    hreset = 1'b1; hbusreq = '0; hlock = '0; htrans = 2'b00; hready = 1'b1;
    model_reset();

    // reset then idle
    repeat (2) cycle();
    hreset = 1'b0;
    repeat (5) cycle();
    check("t1_grant", 32'(hgrant), 32'h1);
    check("t1_lock", 32'(hmastlock), 32'h0);

    // two simultaneous requesters, then handover when owner drops
    hbusreq = 4'b0110;
    cycle();
    check("t2_grant1", 32'(hgrant), 32'h2);
    check("t2_data_lag", 32'(hmaster_data), 32'h0);
    cycle();
    check("t2_data1", 32'(hmaster_data), 32'h1);
    hbusreq = 4'b0100;
    cycle();
    check("t2_grant2", 32'(hgrant), 32'h4);
    check("t2_data_lag2", 32'(hmaster_data), 32'h1);
    cycle();

    // quota: master 2 keeps requesting, master 3 waiting
    hbusreq = 4'b1100; htrans = 2'b11;
    repeat (7) cycle();
    check("t3_before_quota", 32'(hgrant), 32'h4);
    cycle();
    check("t3_after_quota", 32'(hgrant), 32'h8);

    // locked tenure of master 1 with master 0 waiting
    hbusreq = 4'b0010; htrans = 2'b00;
    cycle();
    check("t4_grant1", 32'(hgrant), 32'h2);
    hbusreq = 4'b0011; hlock = 4'b0010; htrans = 2'b11;
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("t4_locked_grant", 32'(hgrant), 32'h2);
      check("t4_mastlock", 32'(hmastlock), 32'h1);
    end
    hlock = 4'b0000;
    cycle();
    check("t4_unlock_grant", 32'(hgrant), 32'h2);
    check("t4_unlock_flag", 32'(hmastlock), 32'h0);
    cycle();
    check("t4_grant0", 32'(hgrant), 32'h1);

    // hready low freezes a pending handover
    hbusreq = 4'b0100; htrans = 2'b00; hready = 1'b0;
    repeat (4) begin
      cycle();
      check("t5_frozen", 32'(hgrant), 32'h1);
    end
    hready = 1'b1;
    cycle();
    check("t5_switch", 32'(hgrant), 32'h4);

    // asynchronous reset while master 3 owns a locked burst
    hbusreq = 4'b1000; htrans = 2'b11;
    cycle();
    hlock = 4'b1000;
    repeat (2) cycle();
    check("t6_pre_lock", 32'(hmastlock), 32'h1);
    hreset = 1'b1;
    #1;
    model_reset();
    check("t6_rst_grant", 32'(hgrant), 32'h1);
    check("t6_rst_master", 32'(hmaster), 32'h0);
    check("t6_rst_data", 32'(hmaster_data), 32'h0);
    check("t6_rst_lock", 32'(hmastlock), 32'h0);
    cycle();
    hreset = 1'b0; hlock = '0; hbusreq = '0; htrans = 2'b00;
    cycle();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      hbusreq = N'($urandom);
      hlock   = N'($urandom & $urandom & $urandom);
      htrans  = 2'($urandom);
      hready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
